serial_pattern_tx: RTL and testbench

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_tx_if.sv | 29 ++
 rtl/serial_pattern_tx.sv | 109 ++++++++++
 tb/tb_serial_pattern_tx.sv | 116 +++++++++++
 3 files changed

// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - request/stream bundle for the serial pattern transmitter
interface serial_pattern_tx_if #(
    parameter int PAT_W = 8,
    parameter int REP_W = 4
);
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic             start_i;
    logic [PAT_W-1:0] pattern_i;
    logic [LEN_W-1:0] len_i;
    logic [REP_W-1:0] repeat_i;
    logic             ready_i;
    logic             data_o;
    logic             valid_o;
    logic             busy_o;
    logic             done_o;

    // Requester side: issues the pattern and accepts the serial stream
    modport master (
        output start_i, pattern_i, len_i, repeat_i, ready_i,
        input  data_o, valid_o, busy_o, done_o
    );

    // Transmitter side
    modport slave (
        input  start_i, pattern_i, len_i, repeat_i, ready_i,
        output data_o, valid_o, busy_o, done_o
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - serialises a captured bit pattern MSB-first with repeats and backpressure
module serial_pattern_tx #(
    parameter int PAT_W = 8,
    parameter int REP_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    serial_pattern_tx_if.slave bus
);
    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam int IDX_W = $clog2(PAT_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] last_q;
    logic [REP_W-1:0] rep_q;
    logic             data_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic [LEN_W-1:0] len_eff;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] dec_idx;

    // Clamp the requested length and derive the first/next bit positions
    always_comb begin
        len_eff   = (bus.len_i > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.len_i;
        start_idx = IDX_W'(len_eff - LEN_W'(1));
        dec_idx   = idx_q - IDX_W'(1);
    end

    // Transmit FSM; outputs are registered alongside the state so they carry no input paths
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            rep_q   <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    data_q  <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    // A zero-length request is dropped silently
                    if (bus.start_i && (bus.len_i != '0)) begin
                        pat_q   <= bus.pattern_i;
                        idx_q   <= start_idx;
                        last_q  <= start_idx;
                        rep_q   <= bus.repeat_i;
                        data_q  <= bus.pattern_i[start_idx];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bus.ready_i) begin
                        if (idx_q != '0) begin
                            idx_q  <= dec_idx;
                            data_q <= pat_q[dec_idx];
                        end else if (rep_q != '0) begin
                            // Wrap straight into the next repetition without a bubble
                            rep_q  <= rep_q - REP_W'(1);
                            idx_q  <= last_q;
                            data_q <= pat_q[last_q];
                        end else begin
                            data_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    data_q  <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - directed self-checking bench for serial_pattern_tx
module tb_serial_pattern_tx;
    logic clk;
    logic rst_n;

    int n_vec  = 0;
    int n_miss = 0;

    serial_pattern_tx_if #(.PAT_W(8), .REP_W(4)) bus ();

    serial_pattern_tx #(.PAT_W(8), .REP_W(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " data"},  32'(bus.data_o),  32'd0);
        check({tag, " valid"}, 32'(bus.valid_o), 32'd0);
        check({tag, " busy"},  32'(bus.busy_o),  32'd0);
        check({tag, " done"},  32'(bus.done_o),  32'd0);
    endtask

    // Issue one start at cycle 0, then check outputs per cycle 1..n against bit-per-cycle masks.
    // ready_mask bit c is the ready level during cycle c; inj_cyc>0 pulses an extra start then.
    task automatic run(input string name, input logic [7:0] pat, input logic [3:0] len,
                       input logic [3:0] rep, input logic [15:0] ready_mask, input int inj_cyc,
                       input logic [15:0] exp_valid, input logic [15:0] exp_data,
                       input logic [15:0] exp_done, input logic [15:0] exp_busy, input int n);
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.pattern_i = pat;
        bus.len_i     = len;
        bus.repeat_i  = rep;
        bus.ready_i   = ready_mask[0];
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            check($sformatf("%s c%0d valid", name, c), 32'(bus.valid_o), 32'(exp_valid[c]));
            check($sformatf("%s c%0d data", name, c),  32'(bus.data_o),  32'(exp_data[c]));
            check($sformatf("%s c%0d done", name, c),  32'(bus.done_o),  32'(exp_done[c]));
            check($sformatf("%s c%0d busy", name, c),  32'(bus.busy_o),  32'(exp_busy[c]));
            bus.ready_i = ready_mask[c];
            if (c == inj_cyc) begin
                bus.start_i   = 1'b1;
                bus.pattern_i = 8'h02;
                bus.len_i     = 4'd2;
                bus.repeat_i  = 4'd0;
            end
        end
        bus.start_i = 1'b0;
        bus.ready_i = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start_i   = 1'b0;
        bus.pattern_i = '0;
        bus.len_i     = '0;
        bus.repeat_i  = '0;
        bus.ready_i   = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post reset");

        run("basic",   8'h05, 4'd3,  4'd0, 16'hFFFF, 0, 16'h000E, 16'h000A, 16'h0010, 16'h001E, 6);
        run("repeat",  8'h05, 4'd3,  4'd2, 16'hFFFF, 0, 16'h03FE, 16'h02DA, 16'h0400, 16'h07FE, 11);
        run("bp",      8'h05, 4'd3,  4'd0, 16'hFFF3, 0, 16'h003E, 16'h0022, 16'h0040, 16'h007E, 7);
        run("ignstart",8'h05, 4'd3,  4'd0, 16'hFFFF, 2, 16'h000E, 16'h000A, 16'h0010, 16'h001E, 6);
        run("len0",    8'h05, 4'd0,  4'd0, 16'hFFFF, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4);
        run("len15",   8'hA5, 4'd15, 4'd0, 16'hFFFF, 0, 16'h01FE, 16'h014A, 16'h0200, 16'h03FE, 10);

        // Reset dropped mid-cycle while bit 2 is on the line
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.pattern_i = 8'h05;
        bus.len_i     = 4'd3;
        bus.repeat_i  = 4'd0;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("rst pre c1 valid", 32'(bus.valid_o), 32'd1);
        @(posedge clk);
        #2;
        check("rst pre c2 valid", 32'(bus.valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("async rst");
        @(negedge clk);
        check_idle("rst held");
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_idle($sformatf("rst released c%0d", c));
        end

        run("after rst", 8'h05, 4'd3, 4'd0, 16'hFFFF, 0, 16'h000E, 16'h000A, 16'h0010, 16'h001E, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
